// File: rtl/alu_sequencer.sv
// Control/writeback stage around the ALU: issues one op at a time, waits out the
// divider latency, writes back and updates NZP. Optional aux writeback via ALU_AUX_WB_EN.
module alu_sequencer #(
    parameter int DIV_CYCLES = 17
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [2:0]  req_dr,
    output logic [2:0]  alu_select,
    output logic        div_start,
    input  logic [15:0] alu_data,
    input  logic [15:0] alu_aux,
    output logic        wb_valid,
    output logic [2:0]  wb_dr,
    output logic [15:0] wb_data,
    output logic [2:0]  nzp,
    output logic        busy,
    output logic        illegal_op
`ifdef ALU_AUX_WB_EN
    ,
    output logic        aux_valid,
    output logic [15:0] aux_data
`endif
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_EXEC      = 3'd1,
        S_DIV_START = 3'd2,
        S_DIV_WAIT  = 3'd3,
        S_WB        = 3'd4
    } state_t;

    localparam logic [2:0] OP_PASS  = 3'b011;
    localparam logic [2:0] OP_MUL   = 3'b100;
    localparam logic [2:0] OP_DIV   = 3'b101;
    localparam logic [5:0] CNT_LOAD = 6'(DIV_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [2:0]  dr_q, dr_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [15:0] wb_data_q, wb_data_d;
    logic [2:0]  wb_dr_q, wb_dr_d;
    logic        wb_valid_q, wb_valid_d;
    logic [2:0]  nzp_q, nzp_d;
    logic        req_ready_q, req_ready_d;
    logic        busy_q, busy_d;
    logic        illegal_q, illegal_d;
    logic [2:0]  select_q, select_d;
    logic        div_start_q, div_start_d;
    logic        capture_s;

    // Exactly one of N/Z/P is set for any value.
    function automatic logic [2:0] nzp_of(input logic [15:0] v);
        logic zero;
        zero   = (v == 16'h0000);
        nzp_of = {v[15], zero, ~v[15] & ~zero};
    endfunction

    // Next-state and next-output logic; outputs are derived from state_d so they register cleanly.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dr_d      = dr_q;
        cnt_d     = cnt_q;
        wb_data_d = wb_data_q;
        nzp_d     = nzp_q;
        illegal_d = 1'b0;
        capture_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_op[2:1] == 2'b11) begin
                        illegal_d = 1'b1;
                    end else begin
                        op_d    = req_op;
                        dr_d    = req_dr;
                        state_d = (req_op == OP_DIV) ? S_DIV_START : S_EXEC;
                    end
                end else begin
                    illegal_d = 1'b0;
                end
            end
            S_EXEC: begin
                capture_s = 1'b1;
                state_d   = S_WB;
            end
            S_DIV_START: begin
                cnt_d   = CNT_LOAD;
                state_d = S_DIV_WAIT;
            end
            S_DIV_WAIT: begin
                if (cnt_q == 6'd0) begin
                    capture_s = 1'b1;
                    state_d   = S_WB;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            S_WB: begin
                nzp_d   = nzp_of(wb_data_q);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (capture_s) begin
            wb_data_d = alu_data;
        end else begin
            wb_data_d = wb_data_d;
        end

        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        wb_valid_d  = (state_d == S_WB);
        wb_dr_d     = (state_d == S_WB) ? dr_d : wb_dr_q;
        div_start_d = (state_d == S_DIV_START);
        select_d    = (state_d == S_IDLE) ? OP_PASS : op_d;
    end

`ifdef ALU_AUX_WB_EN
    logic [15:0] aux_data_q, aux_data_d;
    logic        aux_valid_q, aux_valid_d;
    logic        aux_op_s;

    // Only MUL (high word) and DIV (remainder) produce a meaningful aux result.
    always_comb begin
        aux_op_s    = (op_q == OP_MUL) || (op_q == OP_DIV);
        aux_data_d  = aux_data_q;
        aux_valid_d = 1'b0;
        if (capture_s && aux_op_s) begin
            aux_data_d = alu_aux;
        end else begin
            aux_data_d = aux_data_q;
        end
        if ((state_d == S_WB) && aux_op_s) begin
            aux_valid_d = 1'b1;
        end else begin
            aux_valid_d = 1'b0;
        end
    end

    // Aux writeback registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            aux_data_q  <= 16'h0000;
            aux_valid_q <= 1'b0;
        end else begin
            aux_data_q  <= aux_data_d;
            aux_valid_q <= aux_valid_d;
        end
    end

    assign aux_data  = aux_data_q;
    assign aux_valid = aux_valid_q;
`else
    logic unused_aux_s;
    assign unused_aux_s = ^alu_aux;
`endif

    // Sequencer state and registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            op_q        <= 3'b000;
            dr_q        <= 3'b000;
            cnt_q       <= 6'd0;
            wb_data_q   <= 16'h0000;
            wb_dr_q     <= 3'b000;
            wb_valid_q  <= 1'b0;
            nzp_q       <= 3'b010;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            illegal_q   <= 1'b0;
            select_q    <= OP_PASS;
            div_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            dr_q        <= dr_d;
            cnt_q       <= cnt_d;
            wb_data_q   <= wb_data_d;
            wb_dr_q     <= wb_dr_d;
            wb_valid_q  <= wb_valid_d;
            nzp_q       <= nzp_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            illegal_q   <= illegal_d;
            select_q    <= select_d;
            div_start_q <= div_start_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign busy       = busy_q;
    assign wb_valid   = wb_valid_q;
    assign wb_dr      = wb_dr_q;
    assign wb_data    = wb_data_q;
    assign nzp        = nzp_q;
    assign illegal_op = illegal_q;
    assign alu_select = select_q;
    assign div_start  = div_start_q;

endmodule
